// File: rtl/aes_dec_pkg.sv
// Shared AES decryption types, FSM encoding and the byte/column slicing helpers.
// Column c lives at [127-32c -: 32]; row r inside a column at [31-8r -: 8].
package aes_dec_pkg;

  localparam int AES_NB  = 4;
  localparam int STATE_W = 128;

  typedef logic [7:0]         byte_t;
  typedef logic [31:0]        col_t;
  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  function automatic col_t get_col(input state_t s, input logic [1:0] c);
    case (c)
      2'd0:    return s[127:96];
      2'd1:    return s[95:64];
      2'd2:    return s[63:32];
      default: return s[31:0];
    endcase
  endfunction

  // Row r rotates right by r: shifted[r][c] = s[r][(c-r) mod 4].
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < AES_NB; c++) begin
      for (int r = 0; r < AES_NB; r++) begin
        o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c - r + AES_NB) % AES_NB) - 8*r -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box (FIPS-197 table), one byte in, one byte out.
module aes_inv_sbox
  import aes_dec_pkg::*;
(
  input  byte_t in_byte,
  output byte_t out_byte
);

  // Entry for input x sits at bits [2047-8x -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign out_byte = INV_SBOX[2047 - 8*int'(in_byte) -: 8];

endmodule

// File: rtl/aes_inv_sub_add_round.sv
// Iterative InvShiftRows + InvSubBytes + AddRoundKey, one column per cycle
// through four shared inverse S-boxes, feeding Inverse_Mix_column.
module aes_inv_sub_add_round
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         out_last
);

  fsm_e       fsm_r;
  logic [1:0] col_r;
  state_t     shifted_r;
  state_t     key_r;
  logic       last_r;
  state_t     out_r;
  logic       out_valid_r;
  logic       out_last_r;

  col_t cur_col_s;
  col_t sb_col_s;
  col_t new_col_s;

  assign cur_col_s = get_col(shifted_r, col_r);

  for (genvar i = 0; i < AES_NB; i++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (
      .in_byte  (cur_col_s[31 - 8*i -: 8]),
      .out_byte (sb_col_s[31 - 8*i -: 8])
    );
  end

  assign new_col_s = sb_col_s ^ get_col(key_r, col_r);

  // Gated by rst so nothing is accepted in a reset cycle, even before the first edge.
  assign in_ready  = (fsm_r == IDLE) && !rst;
  assign out_valid = out_valid_r;
  assign state_out = out_r;
  assign out_last  = out_last_r;

  // Handshake FSM, capture registers, column walk and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r       <= IDLE;
      col_r       <= 2'd0;
      shifted_r   <= '0;
      key_r       <= '0;
      last_r      <= 1'b0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (in_valid) begin
            shifted_r <= inv_shift_rows(state_in);
            key_r     <= round_key;
            last_r    <= in_last;
            col_r     <= 2'd0;
            fsm_r     <= BUSY;
          end
        end
        BUSY: begin
          case (col_r)
            2'd0:    out_r[127:96] <= new_col_s;
            2'd1:    out_r[95:64]  <= new_col_s;
            2'd2:    out_r[63:32]  <= new_col_s;
            default: out_r[31:0]   <= new_col_s;
          endcase
          col_r <= col_r + 2'd1;
          // The counter wrap 3->0 and the move to DONE happen on the same edge.
          if (col_r == 2'd3) begin
            fsm_r       <= DONE;
            out_valid_r <= 1'b1;
            out_last_r  <= last_r;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_r       <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          fsm_r       <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_sub_add_round.sv
// Bench for aes_inv_sub_add_round: GF(2^8)-derived reference model, a per-cycle
// output monitor with a transaction queue, directed literal cases and random traffic.
module tb_aes_inv_sub_add_round;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         out_last;

  aes_inv_sub_add_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .round_key (round_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference inverse S-box built from field arithmetic, not from a table.
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_isb();
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] r;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      r = 8'h01;
      for (int k = 0; k < 254; k++) r = gmul(r, b);
      isb[v] = r;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k);
    logic [7:0]   m  [4][4];
    logic [7:0]   kk [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        m[r][c]  = s[127 - 32*c - 8*r -: 8];
        kk[r][c] = k[127 - 32*c - 8*r -: 8];
      end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 32*c - 8*r -: 8] = isb[m[r][(c + 4 - r) % 4]] ^ kk[r][c];
    return o;
  endfunction

  typedef struct {
    logic [127:0] st;
    logic         last;
    int           acc;
  } exp_t;

  exp_t q[$];
  bit   front_seen = 1'b0;
  bit   rst_seen   = 1'b0;
  int   cyc        = 0;

  // Monitor: every negedge, check outputs against the oldest accepted transaction.
  always @(negedge clk) begin
    cyc++;
    if (rst_seen) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_state_out", state_out, 0);
      check("rst_out_last", out_last, 0);
      if (!rst) check("rst_in_ready_after", in_ready, 1);
    end
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        check("model_state", state_out, q[0].st);
        check("model_last", out_last, q[0].last);
        if (!front_seen) begin
          // Accept edge follows this sample; valid shows after the 4th edge beyond it.
          check("latency", cyc - q[0].acc, 5);
          front_seen = 1'b1;
        end
        if (out_ready) begin
          void'(q.pop_front());
          front_seen = 1'b0;
        end
      end
      check("in_ready_in_done", in_ready, 0);
    end
    if (in_valid && in_ready) q.push_back('{model(state_in, round_key), in_last, cyc});
    rst_seen = rst;
    if (rst) begin
      q.delete();
      front_seen = 1'b0;
    end
  end

  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l);
    bit ok;
    state_in  = s;
    round_key = k;
    in_last   = l;
    in_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    state_in  = {$urandom, $urandom, $urandom, $urandom};
    round_key = {$urandom, $urandom, $urandom, $urandom};
    in_last   = 1'($urandom);
  endtask

  task automatic expect_out(input string name, input logic [127:0] s, input logic l);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
    check(name, state_out, s);
    check({name, "_last"}, out_last, l);
    @(posedge clk);
    #1;
  endtask

  logic [127:0] hold;
  bit           got;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    state_in  = '0;
    round_key = '0;
    in_last   = 1'b0;
    build_isb();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    send('0, '0, 1'b0);
    expect_out("zero_state", {16{8'h52}}, 1'b0);

    send({16{8'h63}}, {16{8'hff}}, 1'b1);
    expect_out("all63_keyff", {16{8'hff}}, 1'b1);

    send(128'h00630000_63000000_00000000_00000000, '0, 1'b0);
    expect_out("shift_rows", 128'h52525252_00005252_52525252_52525252, 1'b0);

    // Back-pressure: hold out_ready low for 10 cycles once the result is up.
    out_ready = 1'b0;
    send({4{32'h12345678}}, {4{32'h9abcdef0}}, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("bp_timeout", 0, 1);
    hold = state_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_stable", state_out, hold);
      check("bp_valid_held", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send({16{8'h01}}, '0, 1'b0);
    expect_out("after_bp", {16{8'h09}}, 1'b0);

    // Reset two cycles into BUSY discards the state.
    send({16{8'h00}}, {16{8'h11}}, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send({16{8'h63}}, '0, 1'b1);
    expect_out("post_reset", {16{8'h00}}, 1'b1);

    // Random traffic with random idle gaps and out_ready stalls.
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
      end
      state_in  = {$urandom, $urandom, $urandom, $urandom};
      round_key = {$urandom, $urandom, $urandom, $urandom};
      in_last   = 1'($urandom);
      in_valid  = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        got = in_ready;
        @(posedge clk);
        #1;
        if (got) break;
      end
      if (!got) check("rand_accept_timeout", 0, 1);
      in_valid = 1'b0;
    end

    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    check("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
